// File: rtl/fast_square_pkg.sv
// Shared definitions for the fast-square packer: FSM encoding, marker/header constants.
package fast_square_pkg;
  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_ARM   = 2'd1,
    FS_RUN   = 2'd2,
    FS_FLUSH = 2'd3
  } fs_state_t;

  localparam logic [15:0] FS_MARKER  = 16'h8000;
  localparam logic [3:0]  FS_HDR_TAG = 4'hA;
  localparam int          FS_SEQ_W   = 12;

  // A restart marker needs both halves of the pair set to the marker pattern.
  function automatic logic fs_is_marker(input logic [15:0] i_w, input logic [15:0] q_w);
    return (i_w == FS_MARKER) && (q_w == FS_MARKER);
  endfunction
endpackage

// File: rtl/fast_square_pack_if.sv
// Slicer-pair input and host-FIFO output stream of the packer, bundled as one interface.
interface fast_square_pack_if;
  logic        in_strobe;
  logic [15:0] i_word;
  logic [15:0] q_word;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output in_strobe, i_word, q_word, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  in_strobe, i_word, q_word, out_ready,
    output out_data, out_valid
  );
endinterface

// File: rtl/fast_square_pack_fifo.sv
// fs_pack_fifo: synchronous first-word-fall-through FIFO with a 0-3 word write port
// and a 1-word read port; the writer guarantees it never writes more than the free space.
module fs_pack_fifo #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [1:0]                  wr_n,
    input  logic [2:0][15:0]            wr_words,
    input  logic                        rd_en,
    output logic [15:0]                 rd_data,
    output logic [$clog2(FIFO_DEPTH):0] count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop;

    assign pop     = rd_en && (count != '0);
    assign rd_data = (count == '0) ? 16'h0000 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(wr_n);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + CW'(wr_n) - CW'(pop);
        end
    end

    // Storage is data only; validity is tracked entirely by the pointers and count.
    always_ff @(posedge clock) begin
        for (int k = 0; k < 3; k++) begin
            if (2'(k) < wr_n) mem[wr_ptr + AW'(k)] <= wr_words[k];
        end
    end
endmodule

// File: rtl/fast_square_pack.sv
// fast_square_pack: drops marker pairs, packs I then Q into a FIFO-buffered 16-bit stream.
// Optional header words ahead of each frame when FAST_SQUARE_PACK_HEADER_EN is defined.
module fast_square_pack #(
    parameter int FIFO_DEPTH  = 16,
    parameter int FRAME_PAIRS = 64
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               record,
    fast_square_pack_if.slave  bus,
    output logic               busy,
    output logic               overrun,
    output logic [15:0]        drop_count
);
    import fast_square_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fs_state_t               state, next_state;
    logic [CW-1:0]           fifo_count;
    logic [CW-1:0]           free_words;
    logic [CW-1:0]           need_words;
    logic [11:0]             pair_cnt;
    logic [FS_SEQ_W-1:0]     seq;
    logic                    header_now;
    logic                    marker;
    logic                    accept;
    logic                    fits;
    logic                    push;
    logic                    drop;
    logic                    arm_entry;
    logic [1:0]              wr_n;
    logic [2:0][15:0]        wr_words;
    logic [15:0]             hdr_word;

`ifdef FAST_SQUARE_PACK_HEADER_EN
    assign header_now = (pair_cnt == 12'd0);
`else
    assign header_now = 1'b0;
`endif

    assign marker     = fs_is_marker(bus.i_word, bus.q_word);
    assign hdr_word   = {FS_HDR_TAG, seq};
    assign free_words = CW'(FIFO_DEPTH) - fifo_count;
    assign need_words = header_now ? CW'(3) : CW'(2);
    // Space is judged on start-of-cycle occupancy; a pop in the same cycle does not help.
    assign fits       = (free_words >= need_words);

    always_ff @(posedge clock) begin
        if (reset) state <= FS_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        arm_entry  = 1'b0;
        case (state)
            FS_IDLE: begin
                if (record) begin
                    next_state = FS_ARM;
                    arm_entry  = 1'b1;
                end
            end
            FS_ARM: begin
                if (!record) begin
                    next_state = FS_IDLE;
                end else if (bus.in_strobe && !marker) begin
                    accept     = 1'b1;
                    next_state = FS_RUN;
                end
            end
            FS_RUN: begin
                if (!record) next_state = FS_FLUSH;
                else         accept     = bus.in_strobe && !marker;
            end
            FS_FLUSH: begin
                if (fifo_count == '0) next_state = FS_IDLE;
            end
            default: next_state = FS_IDLE;
        endcase
    end

    assign push = accept && fits;
    assign drop = accept && !fits;

    always_comb begin
        wr_n     = 2'd0;
        wr_words = '0;
        if (push) begin
            if (header_now) begin
                wr_n        = 2'd3;
                wr_words[0] = hdr_word;
                wr_words[1] = bus.i_word;
                wr_words[2] = bus.q_word;
            end else begin
                wr_n        = 2'd2;
                wr_words[0] = bus.i_word;
                wr_words[1] = bus.q_word;
            end
        end
    end

    // Frame position, sequence number and overrun bookkeeping; all restart on ARM entry.
    always_ff @(posedge clock) begin
        if (reset || arm_entry) begin
            pair_cnt   <= 12'd0;
            seq        <= '0;
            overrun    <= 1'b0;
            drop_count <= 16'h0000;
        end else begin
            if (push) begin
                if (pair_cnt == 12'(FRAME_PAIRS - 1)) begin
                    pair_cnt <= 12'd0;
                    seq      <= seq + 1'b1;
                end else begin
                    pair_cnt <= pair_cnt + 12'd1;
                end
            end
            if (drop) begin
                overrun <= 1'b1;
                if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end
        end
    end

    fs_pack_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .wr_n     (wr_n),
        .wr_words (wr_words),
        .rd_en    (bus.out_ready),
        .rd_data  (bus.out_data),
        .count    (fifo_count)
    );

    assign bus.out_valid = (fifo_count != '0);
    assign busy          = (state != FS_IDLE);
endmodule

// File: tb/tb_fast_square_pack.sv
// Bench for fast_square_pack: directed table, corner sequences and random traffic vs a queue model.
module tb_fast_square_pack;
  localparam int DEPTH  = 16;
  localparam int FRAMES = 2;
`ifdef FAST_SQUARE_PACK_HEADER_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  logic record;
  logic busy;
  logic overrun;
  logic [15:0] drop_count;

  fast_square_pack_if bus ();

  fast_square_pack #(.FIFO_DEPTH(DEPTH), .FRAME_PAIRS(FRAMES)) dut (
    .clock(clock), .reset(reset), .record(record), .bus(bus),
    .busy(busy), .overrun(overrun), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model: expected stream as a queue plus the capture mode and counters.
  logic [15:0] mq[$];
  int mmode;    // 0 idle, 1 armed, 2 running, 3 flushing
  int mdrop;
  bit movr;
  int mpc;
  int mseq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_eval();
    int occ, need;
    bit pop, mark, take, fits;
    if (reset) begin
      mq.delete(); mmode = 0; mdrop = 0; movr = 0; mpc = 0; mseq = 0;
      return;
    end
    occ  = mq.size();
    pop  = (occ > 0) && bus.out_ready;
    mark = (bus.i_word == 16'h8000) && (bus.q_word == 16'h8000);
    take = bus.in_strobe && !mark && record && (mmode == 1 || mmode == 2);
    need = (HDR && mpc == 0) ? 3 : 2;
    fits = (DEPTH - occ) >= need;
    if (pop) void'(mq.pop_front());
    if (take && fits) begin
      if (HDR && mpc == 0) mq.push_back({4'hA, 12'(mseq)});
      mq.push_back(bus.i_word);
      mq.push_back(bus.q_word);
      mpc = mpc + 1;
      if (mpc == FRAMES) begin mpc = 0; mseq = (mseq + 1) % 4096; end
    end else if (take) begin
      movr = 1;
      if (mdrop < 65535) mdrop++;
    end
    case (mmode)
      0: if (record) begin mmode = 1; mdrop = 0; movr = 0; mpc = 0; mseq = 0; end
      1: if (!record) mmode = 0; else if (take) mmode = 2;
      2: if (!record) mmode = 3;
      default: if (occ == 0) mmode = 0;
    endcase
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'(mq.size() > 0));
    chk({tag, "_data"},  32'(bus.out_data),  (mq.size() > 0) ? 32'(mq[0]) : 32'h0);
    chk({tag, "_busy"},  32'(busy),          32'(mmode != 0));
    chk({tag, "_ovr"},   32'(overrun),       32'(movr));
    chk({tag, "_drops"}, 32'(drop_count),    32'(mdrop));
  endtask

  task automatic step(input bit do_chk, input string tag);
    model_eval();
    @(posedge clock);
    #1;
    if (do_chk) check_model(tag);
  endtask

  task automatic drive(input logic rec, input logic stb, input logic [15:0] iw,
                       input logic [15:0] qw, input logic rdy);
    record = rec; bus.in_strobe = stb; bus.i_word = iw; bus.q_word = qw; bus.out_ready = rdy;
  endtask

  task automatic do_reset();
    drive(0, 0, 16'h0, 16'h0, 0);
    reset = 1'b1;
    step(0, "rst");
    step(0, "rst");
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_data",  32'(bus.out_data),  32'h0);
    chk("rst_busy",  32'(busy),          32'h0);
    chk("rst_ovr",   32'(overrun),       32'h0);
    chk("rst_drops", 32'(drop_count),    32'h0);
    reset = 1'b0;
  endtask

  typedef struct {
    logic rec; logic stb; logic [15:0] iw; logic [15:0] qw; logic rdy;
    logic ev; logic [15:0] ed; logic eb;
  } vec_t;

  vec_t tbl[17];

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int cnt, guard;
    logic [15:0] exp6[8];

    reset = 1'b1;
    drive(0, 0, 16'h0, 16'h0, 0);

    // Directed table: basic pack order, latency, flush, markers in ARM/RUN, half-marker.
    tbl[0]  = '{1, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 1};
    tbl[1]  = '{1, 1, 16'h1234, 16'hABCD, 1, 1, 16'h1234, 1};
    tbl[2]  = '{1, 0, 16'h0000, 16'h0000, 1, 1, 16'hABCD, 1};
    tbl[3]  = '{1, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 1};
    tbl[4]  = '{0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 1};
    tbl[5]  = '{0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 0};
    tbl[6]  = '{1, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 1};
    tbl[7]  = '{1, 1, 16'h8000, 16'h8000, 1, 0, 16'h0000, 1};
    tbl[8]  = '{1, 1, 16'h8000, 16'h8000, 1, 0, 16'h0000, 1};
    tbl[9]  = '{1, 1, 16'h8000, 16'h8000, 1, 0, 16'h0000, 1};
    tbl[10] = '{1, 1, 16'h0001, 16'h0002, 1, 1, 16'h0001, 1};
    tbl[11] = '{1, 0, 16'h0000, 16'h0000, 1, 1, 16'h0002, 1};
    tbl[12] = '{1, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 1};
    tbl[13] = '{1, 1, 16'h8000, 16'h8000, 1, 0, 16'h0000, 1};
    tbl[14] = '{1, 1, 16'h8000, 16'h0005, 1, 1, 16'h8000, 1};
    tbl[15] = '{1, 0, 16'h0000, 16'h0000, 1, 1, 16'h0005, 1};
    tbl[16] = '{1, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 1};

    do_reset();
    if (!HDR) begin
      for (int i = 0; i < 17; i++) begin
        drive(tbl[i].rec, tbl[i].stb, tbl[i].iw, tbl[i].qw, tbl[i].rdy);
        step(0, "tbl");
        chk($sformatf("tbl%0d_valid", i), 32'(bus.out_valid), 32'(tbl[i].ev));
        chk($sformatf("tbl%0d_data", i),  32'(bus.out_data),  32'(tbl[i].ed));
        chk($sformatf("tbl%0d_busy", i),  32'(busy),          32'(tbl[i].eb));
      end
    end

    // Overrun: consumer stalled, nine strobes into a 16-word FIFO.
    do_reset();
    drive(1, 0, 16'h0, 16'h0, 0);
    step(1, "ovr_arm");
    for (int k = 0; k < 9; k++) begin
      drive(1, 1, 16'(16'h0100 + k), 16'(16'h0200 + k), 0);
      step(1, "ovr_fill");
    end
    if (!HDR) begin
      chk("ovr_flag",  32'(overrun),    32'h1);
      chk("ovr_count", 32'(drop_count), 32'h1);
    end
    drive(1, 0, 16'h0, 16'h0, 1);
    for (int k = 0; k < 20; k++) step(1, "ovr_drain");

    // Saturation: keep stalled and hammer strobes past 65535 drops.
    drive(1, 1, 16'h0F0F, 16'hF0F0, 0);
    for (int k = 0; k < 65545; k++) step(0, "sat");
    chk("sat_count", 32'(drop_count), 32'hFFFF);
    chk("sat_flag",  32'(overrun),    32'h1);
    check_model("sat");
    drive(1, 0, 16'h0, 16'h0, 1);
    for (int k = 0; k < 20; k++) step(1, "sat_drain");

    // Flush: words queued, record dropped, everything drains then IDLE.
    do_reset();
    drive(1, 0, 16'h0, 16'h0, 0);
    step(1, "fl_arm");
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 16'(16'h3000 + k), 16'(16'h4000 + k), 0);
      step(1, "fl_fill");
    end
    drive(0, 0, 16'h0, 16'h0, 1);
    cnt = 0; guard = 0;
    while (busy && guard < 40) begin
      if (bus.out_valid) cnt++;
      step(1, "fl_drain");
      guard++;
    end
    chk("fl_words",   32'(cnt),   HDR ? 32'd8 : 32'd6);
    chk("fl_idle",    32'(busy),  32'h0);
    chk("fl_timeout", 32'(guard < 40), 32'h1);

`ifdef FAST_SQUARE_PACK_HEADER_EN
    // Header framing with two pairs per frame.
    do_reset();
    drive(1, 0, 16'h0, 16'h0, 0);
    step(1, "hdr_arm");
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 16'(16'h1100 + k), 16'(16'h2200 + k), 0);
      step(1, "hdr_fill");
    end
    exp6 = '{16'hA000, 16'h1100, 16'h2200, 16'h1101, 16'h2201, 16'hA001, 16'h1102, 16'h2202};
    drive(1, 0, 16'h0, 16'h0, 1);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("hdr_word%0d", k), 32'(bus.out_data), 32'(exp6[k]));
      step(1, "hdr_pop");
    end
`else
    exp6 = '{default: 16'h0};
    chk("hdr_off_unused", 32'(exp6[0]), 32'(bus.out_data));
`endif

    // Reset in the middle of a stream discards buffered words.
    drive(1, 0, 16'h0, 16'h0, 0);
    step(1, "mr_arm");
    for (int k = 0; k < 2; k++) begin
      drive(1, 1, 16'(16'h5000 + k), 16'(16'h6000 + k), 0);
      step(1, "mr_fill");
    end
    chk("mr_before", 32'(bus.out_valid), 32'h1);
    reset = 1'b1;
    drive(0, 0, 16'h0, 16'h0, 1);
    step(1, "mr_rst");
    chk("mr_valid", 32'(bus.out_valid), 32'h0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) step(1, "mr_after");

    // Random traffic: record toggling, markers, bursts and backpressure.
    do_reset();
    drive(1, 0, 16'h0, 16'h0, 0);
    for (int k = 0; k < 4000; k++) begin
      logic stb, mk;
      if ($urandom_range(63) == 0) record = ~record;
      stb = ($urandom_range(2) == 0);
      mk  = ($urandom_range(7) == 0);
      bus.in_strobe = stb;
      bus.i_word    = mk ? 16'h8000 : 16'($urandom);
      bus.q_word    = mk ? 16'h8000 : 16'($urandom);
      bus.out_ready = (k % 512 < 256) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
      step(1, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
